// File: rtl/idma_rd_req_sched_if.sv
// Requester-side and iDMA command-side signals of the read request scheduler.
// master = scheduler, slave = requesters plus the iDMA read channel.
interface idma_rd_req_sched_if #(
  parameter int NREQ     = 4,
  parameter int ADDR_WID = 32
);
  logic [NREQ-1:0]               req_valid;
  logic [NREQ-1:0][ADDR_WID-1:0] req_addr;
  logic [NREQ-1:0][31:0]         req_num;
  logic [NREQ-1:0]               req_ready;
  logic [NREQ-1:0]               req_done;
  logic                          dma_req;
  logic [ADDR_WID-1:0]           dma_addr;
  logic [31:0]                   dma_num;
  logic                          dma_addr_ready;
  logic                          dma_done;

  modport master (
    input  req_valid, req_addr, req_num, dma_addr_ready, dma_done,
    output req_ready, req_done, dma_req, dma_addr, dma_num
  );
  modport slave (
    output req_valid, req_addr, req_num, dma_addr_ready, dma_done,
    input  req_ready, req_done, dma_req, dma_addr, dma_num
  );
endinterface

// File: rtl/idma_rd_req_sched.sv
// Round-robin read command scheduler: grants one transfer at a time and feeds it
// to the iDMA read port in chunks of at most MAX_CHUNK words.
module idma_rd_req_sched #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int MAX_CHUNK = 256,
  parameter int ADDR_WID  = 32
) (
  input  logic                aclk,
  input  logic                areset,
  idma_rd_req_sched_if.master bus,
  output logic [IDW-1:0]      grant_id,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic [31:0] MAXC = 32'(MAX_CHUNK);

  state_t              state_q, state_n;
  logic [IDW-1:0]      rr_q, rr_n, gid_n, sel;
  logic [31:0]         rem_q, rem_n, num_n, rem_dec;
  logic [ADDR_WID-1:0] addr_n, addr_inc;
  logic                req_n, found;
  logic [NREQ-1:0]     rdy_n, done_n, vld_eff;
  int                  j;

  function automatic logic [31:0] clip(input logic [31:0] n);
    return (n > MAXC) ? MAXC : n;
  endfunction

  function automatic logic [IDW-1:0] nxt(input logic [IDW-1:0] x);
    return (x == IDW'(NREQ-1)) ? '0 : x + 1'b1;
  endfunction

  // A requester whose ready pulse is still on the wire has not yet had a
  // chance to drop valid, so it must not be granted a second time.
  always_comb begin
    found   = 1'b0;
    sel     = '0;
    j       = 0;
    vld_eff = bus.req_valid & ~bus.req_ready;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && vld_eff[j]) begin
        found = 1'b1;
        sel   = IDW'(j);
      end
    end
  end

  // dma_addr / dma_num double as the current address and chunk registers.
  always_comb begin
    rem_dec  = rem_q - bus.dma_num;
    addr_inc = bus.dma_addr + ADDR_WID'({bus.dma_num, 5'b0});
    state_n  = state_q;
    rr_n     = rr_q;
    rem_n    = rem_q;
    gid_n    = grant_id;
    addr_n   = bus.dma_addr;
    num_n    = bus.dma_num;
    req_n    = bus.dma_req;
    rdy_n    = '0;
    done_n   = '0;
    case (state_q)
      IDLE: if (found) begin
        gid_n      = sel;
        addr_n     = bus.req_addr[sel];
        rem_n      = bus.req_num[sel];
        num_n      = clip(bus.req_num[sel]);
        rdy_n[sel] = 1'b1;
        if (bus.req_num[sel] == 32'd0) begin
          done_n[sel] = 1'b1;
          rr_n        = nxt(sel);
        end else begin
          req_n   = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: if (bus.dma_addr_ready) begin
        req_n   = 1'b0;
        state_n = WAIT;
      end
      WAIT: if (bus.dma_done) begin
        rem_n  = rem_dec;
        addr_n = addr_inc;
        if (rem_dec == 32'd0) begin
          done_n[grant_id] = 1'b1;
          rr_n             = nxt(grant_id);
          state_n          = IDLE;
        end else begin
          num_n   = clip(rem_dec);
          req_n   = 1'b1;
          state_n = ISSUE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      rem_q         <= '0;
      grant_id      <= '0;
      busy          <= 1'b0;
      bus.dma_req   <= 1'b0;
      bus.dma_addr  <= '0;
      bus.dma_num   <= '0;
      bus.req_ready <= '0;
      bus.req_done  <= '0;
    end else begin
      state_q       <= state_n;
      rr_q          <= rr_n;
      rem_q         <= rem_n;
      grant_id      <= gid_n;
      busy          <= (state_n != IDLE);
      bus.dma_req   <= req_n;
      bus.dma_addr  <= addr_n;
      bus.dma_num   <= num_n;
      bus.req_ready <= rdy_n;
      bus.req_done  <= done_n;
    end
  end
endmodule

// File: tb/tb_idma_rd_req_sched.sv
// Directed bench for idma_rd_req_sched: one DUT with MAX_CHUNK=256, one with
// MAX_CHUNK=1 for the address-wrap case.
module tb_idma_rd_req_sched;
  logic       aclk = 1'b0;
  logic       areset;
  logic [1:0] gid0, gid1;
  logic       busy0, busy1;
  int         checks = 0;
  int         errors = 0;

  idma_rd_req_sched_if #(.NREQ(4), .ADDR_WID(32)) if0 ();
  idma_rd_req_sched_if #(.NREQ(4), .ADDR_WID(32)) if1 ();

  idma_rd_req_sched #(.NREQ(4), .IDW(2), .MAX_CHUNK(256), .ADDR_WID(32)) u_dut (
    .aclk(aclk), .areset(areset), .bus(if0.master), .grant_id(gid0), .busy(busy0));
  idma_rd_req_sched #(.NREQ(4), .IDW(2), .MAX_CHUNK(1), .ADDR_WID(32)) u_wrap (
    .aclk(aclk), .areset(areset), .bus(if1.master), .grant_id(gid1), .busy(busy1));

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expects a command on the bus now, accepts it at once, then returns the done.
  task automatic serve(input string tag, input logic [31:0] a, input logic [31:0] n);
    chk({tag, "_req"},  64'(if0.dma_req),  64'd1);
    chk({tag, "_addr"}, 64'(if0.dma_addr), 64'(a));
    chk({tag, "_num"},  64'(if0.dma_num),  64'(n));
    if0.dma_addr_ready = 1'b1;
    tick();
    chk({tag, "_drop"}, 64'(if0.dma_req), 64'd0);
    if0.dma_addr_ready = 1'b0;
    if0.dma_done = 1'b1;
    tick();
    if0.dma_done = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dreq"},  64'(if0.dma_req),   64'd0);
    chk({tag, "_daddr"}, 64'(if0.dma_addr),  64'd0);
    chk({tag, "_dnum"},  64'(if0.dma_num),   64'd0);
    chk({tag, "_rdy"},   64'(if0.req_ready), 64'd0);
    chk({tag, "_done"},  64'(if0.req_done),  64'd0);
    chk({tag, "_gid"},   64'(gid0),          64'd0);
    chk({tag, "_busy"},  64'(busy0),         64'd0);
  endtask

  initial begin
    logic [1:0] rr_exp [5];
    logic [1:0] alt_exp [3];
    rr_exp  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    alt_exp = '{2'd1, 2'd3, 2'd1};
    areset = 1'b1;
    if0.req_valid = '0; if0.req_addr = '0; if0.req_num = '0;
    if0.dma_addr_ready = 1'b0; if0.dma_done = 1'b0;
    if1.req_valid = '0; if1.req_addr = '0; if1.req_num = '0;
    if1.dma_addr_ready = 1'b0; if1.dma_done = 1'b0;
    tick(); tick();
    chk_reset_vals("rst");
    areset = 1'b0;
    tick();

    // single request
    if0.req_addr[0] = 32'h1000_0000; if0.req_num[0] = 32'd10; if0.req_valid = 4'b0001;
    tick();
    chk("single_rdy",  64'(if0.req_ready), 64'h1);
    chk("single_busy", 64'(busy0), 64'd1);
    if0.req_valid = '0;
    serve("single", 32'h1000_0000, 32'd10);
    chk("single_done", 64'(if0.req_done), 64'h1);
    chk("single_idle", 64'(busy0), 64'd0);
    tick();
    chk("single_done_pulse", 64'(if0.req_done), 64'h0);

    // chunk split 600 = 256 + 256 + 88
    if0.req_addr[1] = 32'h0; if0.req_num[1] = 32'd600; if0.req_valid = 4'b0010;
    tick();
    chk("split_rdy", 64'(if0.req_ready), 64'h2);
    chk("split_gid", 64'(gid0), 64'd1);
    if0.req_valid = '0;
    serve("split0", 32'h0000, 32'd256);
    chk("split0_nodone", 64'(if0.req_done), 64'h0);
    serve("split1", 32'h2000, 32'd256);
    chk("split1_nodone", 64'(if0.req_done), 64'h0);
    serve("split2", 32'h4000, 32'd88);
    chk("split_done", 64'(if0.req_done), 64'h2);
    tick();
    chk("split_done_once", 64'(if0.req_done), 64'h0);

    // round robin from a fresh pointer
    areset = 1'b1; tick(); areset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if0.req_addr[i] = 32'(i) * 32'h100; if0.req_num[i] = 32'd1;
    end
    if0.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_rdy", 64'(if0.req_ready), 64'(4'b0001 << rr_exp[i]));
      chk("rr_gid", 64'(gid0), 64'(rr_exp[i]));
      serve("rr", 32'(rr_exp[i]) * 32'h100, 32'd1);
      chk("rr_done", 64'(if0.req_done), 64'(4'b0001 << rr_exp[i]));
    end
    if0.req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("alt_rdy", 64'(if0.req_ready), 64'(4'b0001 << alt_exp[i]));
      serve("alt", 32'(alt_exp[i]) * 32'h100, 32'd1);
      chk("alt_done", 64'(if0.req_done), 64'(4'b0001 << alt_exp[i]));
    end
    if0.req_valid = '0;
    tick();

    // zero length on requester 2, valid held one edge past the ready pulse
    if0.req_num[2] = 32'd0; if0.req_valid = 4'b0100;
    tick();
    chk("zero_rdy",  64'(if0.req_ready), 64'h4);
    chk("zero_done", 64'(if0.req_done),  64'h4);
    chk("zero_dreq", 64'(if0.dma_req),   64'd0);
    chk("zero_busy", 64'(busy0),         64'd0);
    tick();
    chk("zero_norepeat", 64'(if0.req_ready), 64'h0);
    chk("zero_dreq2",    64'(if0.dma_req),   64'd0);
    if0.req_valid = '0;
    tick();

    // backpressure with a spurious done during ISSUE; rr_ptr is now 3
    if0.req_addr[3] = 32'h2000_0000; if0.req_num[3] = 32'd300; if0.req_valid = 4'b1000;
    tick();
    chk("bp_rdy", 64'(if0.req_ready), 64'h8);
    if0.req_valid = '0;
    for (int c = 0; c < 20; c++) begin
      chk("bp_req",  64'(if0.dma_req),  64'd1);
      chk("bp_addr", 64'(if0.dma_addr), 64'h2000_0000);
      chk("bp_num",  64'(if0.dma_num),  64'd256);
      if0.dma_done = (c == 5);
      tick();
    end
    if0.dma_done = 1'b0;
    serve("bp0", 32'h2000_0000, 32'd256);
    serve("bp1", 32'h2000_2000, 32'd44);
    chk("bp_done", 64'(if0.req_done), 64'h8);
    tick();

    // mid-operation reset; rr_ptr is 0, a zero-length on 1 moves it to 2
    if0.req_num[1] = 32'd0; if0.req_valid = 4'b0010;
    tick();
    chk("mr_zero_done", 64'(if0.req_done), 64'h2);
    if0.req_valid = '0;
    tick();
    if0.req_addr[2] = 32'h3000; if0.req_num[2] = 32'd400; if0.req_valid = 4'b0100;
    tick();
    chk("mr_rdy", 64'(if0.req_ready), 64'h4);
    if0.req_valid = '0;
    if0.dma_addr_ready = 1'b1;
    tick();
    if0.dma_addr_ready = 1'b0;
    chk("mr_wait_busy", 64'(busy0), 64'd1);
    areset = 1'b1;
    tick();
    chk_reset_vals("mr");
    areset = 1'b0;
    if0.dma_done = 1'b1;
    tick();
    if0.dma_done = 1'b0;
    chk("mr_no_done", 64'(if0.req_done), 64'h0);
    chk("mr_idle",    64'(busy0),        64'd0);
    if0.req_addr[0] = 32'h40; if0.req_num[0] = 32'd1; if0.req_valid = 4'b0101;
    tick();
    chk("mr_first0", 64'(if0.req_ready), 64'h1);
    if0.req_valid = '0;
    serve("mr", 32'h40, 32'd1);
    chk("mr_done0", 64'(if0.req_done), 64'h1);
    tick();

    // address wrap on the MAX_CHUNK=1 instance
    if1.req_addr[0] = 32'hFFFF_FFE0; if1.req_num[0] = 32'd2; if1.req_valid = 4'b0001;
    tick();
    chk("wrap_rdy", 64'(if1.req_ready), 64'h1);
    if1.req_valid = '0;
    chk("wrap0_req",  64'(if1.dma_req),  64'd1);
    chk("wrap0_addr", 64'(if1.dma_addr), 64'hFFFF_FFE0);
    chk("wrap0_num",  64'(if1.dma_num),  64'd1);
    if1.dma_addr_ready = 1'b1; tick(); if1.dma_addr_ready = 1'b0;
    if1.dma_done = 1'b1; tick(); if1.dma_done = 1'b0;
    chk("wrap1_req",  64'(if1.dma_req),  64'd1);
    chk("wrap1_addr", 64'(if1.dma_addr), 64'h0);
    chk("wrap1_num",  64'(if1.dma_num),  64'd1);
    chk("wrap1_nodone", 64'(if1.req_done), 64'h0);
    if1.dma_addr_ready = 1'b1; tick(); if1.dma_addr_ready = 1'b0;
    if1.dma_done = 1'b1; tick(); if1.dma_done = 1'b0;
    chk("wrap_done", 64'(if1.req_done), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
